uprocesador_multiciclo: RTL
===========================

Name: uprocesador_multiciclo

Overview:
Parametrised multicycle microprocessor core and successor to the fixed-width 8-bit processor top. It fetches instructions over a req/ack instruction-memory handshake and executes them through an FSM with states FETCH, DECODE, FETCH_IMM, EXEC and HALT. It contains a register file with two read-only fixed registers, an ALU with a shifter, Z/C/N flags, and a registered output port. It sits under the processor top and replaces the hard-wired control/datapath pairing.

Parameters:
DATAWIDTH_BUS, 8, data/register width
NUM_REGS, 8, register count (minimum 4)
REG_ADDR_W, 3, register index width (equals clog2(NUM_REGS))
PC_W, 8, program counter and imem address width
INSTR_W, 16, instruction word width (must be at least 4+3*REG_ADDR_W and at least max(DATAWIDTH_BUS, PC_W))
DATA_REGFIXED_INIT_0, 8'h09, constant value of R[NUM_REGS-2]
DATA_REGFIXED_INIT_1, 8'h0F, constant value of R[NUM_REGS-1]

Ports:
CLOCK_50  in  1  system clock, rising edge
Reset_InLow  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address
imem_rdata  in  INSTR_W  fetched word, valid when imem_ack=1
imem_ack  in  1  fetch completion
out_data  out  DATAWIDTH_BUS  last OUT value
out_valid  out  1  one-cycle pulse per OUT
flags  out  3  {Z,C,N}
pc_dbg  out  PC_W  current PC
halted  out  1  core is in HALT

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset_InLow is asynchronous and active-low.
- Reset values: pc=0, state=FETCH, all writable registers=0, flags=0, out_data=0, out_valid=0, halted=0, imem_req=0.
- First request: imem_req rises in the first clock after reset release.
- Reset asserted mid-fetch: imem_req drops immediately (asynchronous). Any later ack is ignored.
- Instruction encoding: opcode=[INSTR_W-1 -:4], rd=next REG_ADDR_W bits, rs1=next, rs2=next.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 NOT rs1
  - 7 SHL rs1 by 1, 8 SHR (logical) rs1 by 1, 9 ASR rs1 by 1
  - A LDI
  - B MOV rd<=rs1
  - C BZ
  - D JMP
  - E OUT rs1
  - F HALT
- Immediate instructions: LDI, BZ and JMP use a second word at pc+1. LDI takes its low DATAWIDTH_BUS bits; BZ and JMP take its low PC_W bits.
- Handshake:
  - In FETCH and FETCH_IMM, imem_req=1 and imem_addr is held stable until a cycle with imem_ack=1. The word is captured in that cycle.
  - imem_req deasserts the following cycle.
  - Ack while req=0 is ignored. Ack may arrive in the same cycle as req (zero wait).
- Transitions:
  - FETCH --ack--> DECODE.
  - DECODE -> FETCH_IMM for A/C/D; HALT for F; otherwise EXEC.
  - FETCH_IMM --ack--> EXEC.
  - EXEC -> FETCH.
  - HALT is terminal: req stays 0 and acks are ignored. Only reset exits HALT.
- Latency with zero-wait ack: 3 cycles for a one-word instruction, 4 cycles for a two-word instruction.
- EXEC actions:
  - Register write and flag update happen at the end of EXEC.
  - pc advances by 1 (one-word) or 2 (two-word) modulo 2^PC_W. Wrap FF->00 is legal.
  - JMP: pc <= imm.
  - BZ: pc <= imm if Z=1, else pc+2.
- Flags:
  - Updated only by opcodes 1-9. Z = result==0; N = result MSB.
  - C for ADD: carry-out. C for SUB: borrow (rs1<rs2 unsigned).
  - C for SHL: bit shifted out of the MSB. C for SHR/ASR: bit shifted out of the LSB.
  - C=0 for logic ops and NOT. LDI, MOV and OUT leave flags unchanged.
- Fixed registers: R[NUM_REGS-2] and R[NUM_REGS-1] always read their INIT constants. Writes to them are silently dropped, but flags still update.
- Read/write ordering: register read happens in EXEC from pre-write values. rd==rs1 is legal.
- OUT: out_data <= R[rs1]; out_valid=1 for exactly the cycle after EXEC. out_data holds its value until the next OUT.
- halted=1 from the cycle HALT is entered.

Decomposition:
- Package uproc_pkg: opcode localparams, FSM state encoding, flag bit indices (Z=2, C=1, N=0).
- Sub-module uproc_alu: combinational ALU and shifter. Inputs: op, a, b. Outputs: result and {Z,C,N}, parametrised by DATAWIDTH_BUS.
- Register file and FSM stay inline.

Test Plan:
1. Hold Reset_InLow=0 for 3 cycles -> all outputs at reset values. After release -> imem_req=1 with imem_addr=0 in the next cycle.
2. Program: LDI R1,0x05; ADD R2,R1,R6; OUT R2 -> out_data=0x0E, one-cycle out_valid pulse, flags Z=0 C=0 N=0.
3. Arithmetic flags:
   - SUB R3,R1,R7 (5-15) -> R3=0xF6, Z=0 C=1 N=1.
   - With R4=0xFF, R5=0x01: ADD -> 0x00, Z=1 C=1.
4. LDI R6,0x55 then OUT R6 -> out_data=0x09 (write ignored). SHL of 0x81 -> 0x02, C=1.
5. Ack delayed 3 cycles -> imem_req/imem_addr stable for all 4 cycles. BZ with Z=1 goes to target; BZ with Z=0 goes to pc+2. A NOP at 0xFF wraps the PC to 0x00.
6. HALT -> halted=1, imem_req stays 0 under spurious acks. Reset_InLow pulsed low mid-HALT -> pc=0 and fetch restarts.

Source files
------------

// File: rtl/uproc_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states, flag bit positions.
package uproc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_ASR  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_FETCH_IMM,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 0;

  // Instructions that carry an immediate word at pc+1.
  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_BZ) || (op == OP_JMP);
  endfunction

  // ALU/shift opcodes are the only ones that touch the flags.
  function automatic logic updates_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_ASR);
  endfunction

endpackage

// File: rtl/uproc_alu.sv
// Combinational ALU and single-bit shifter with Z/C/N generation.
module uproc_alu
  import uproc_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = 8
) (
  input  logic [3:0]               op_i,
  input  logic [DATAWIDTH_BUS-1:0] a_i,
  input  logic [DATAWIDTH_BUS-1:0] b_i,
  output logic [DATAWIDTH_BUS-1:0] result_o,
  output logic [2:0]               flags_o
);

  logic [DATAWIDTH_BUS-1:0] res;
  logic                     carry;

  // Result and carry per opcode; C is borrow for SUB and the shifted-out bit for shifts.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op_i)
      OP_ADD: {carry, res} = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB: begin
        res   = a_i - b_i;
        carry = (a_i < b_i);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_NOT: res = ~a_i;
      OP_SHL: begin
        res   = {a_i[DATAWIDTH_BUS-2:0], 1'b0};
        carry = a_i[DATAWIDTH_BUS-1];
      end
      OP_SHR: begin
        res   = {1'b0, a_i[DATAWIDTH_BUS-1:1]};
        carry = a_i[0];
      end
      OP_ASR: begin
        res   = {a_i[DATAWIDTH_BUS-1], a_i[DATAWIDTH_BUS-1:1]};
        carry = a_i[0];
      end
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

  // Flag vector assembled from the result.
  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (res == '0);
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_N] = res[DATAWIDTH_BUS-1];
  end

  assign result_o = res;

endmodule

// File: rtl/uprocesador_multiciclo.sv
// Parametrised multicycle core: req/ack instruction fetch, FSM sequencing, register file with two constant registers.
module uprocesador_multiciclo
  import uproc_pkg::*;
#(
  parameter int unsigned             DATAWIDTH_BUS        = 8,
  parameter int unsigned             NUM_REGS             = 8,
  parameter int unsigned             REG_ADDR_W           = 3,
  parameter int unsigned             PC_W                 = 8,
  parameter int unsigned             INSTR_W              = 16,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_0 = 8'h09,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_1 = 8'h0F
) (
  input  logic                     CLOCK_50,
  input  logic                     Reset_InLow,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     imem_ack,
  output logic [DATAWIDTH_BUS-1:0] out_data,
  output logic                     out_valid,
  output logic [2:0]               flags,
  output logic [PC_W-1:0]          pc_dbg,
  output logic                     halted
);

  localparam int unsigned IR_W   = 4 + 3 * REG_ADDR_W;
  localparam int unsigned IMM_W  = (DATAWIDTH_BUS > PC_W) ? DATAWIDTH_BUS : PC_W;
  localparam int unsigned NUM_WR = NUM_REGS - 2;

  state_t                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [IR_W-1:0]          ir_q, ir_d;
  logic [IMM_W-1:0]         imm_q, imm_d;
  logic [2:0]               flags_q, flags_d;
  logic [DATAWIDTH_BUS-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     req_q, req_d;
  logic [DATAWIDTH_BUS-1:0] regs_q [NUM_WR];

  logic [3:0]               opcode;
  logic [REG_ADDR_W-1:0]    rd, rs1, rs2;
  logic [DATAWIDTH_BUS-1:0] rs1_val, rs2_val, alu_res, wdata;
  logic [2:0]               alu_flags;
  logic                     we, fire;

  // Only the opcode and register fields of the first word are kept.
  assign opcode = ir_q[IR_W-1 -: 4];
  assign rd     = ir_q[IR_W-5 -: REG_ADDR_W];
  assign rs1    = ir_q[IR_W-5-REG_ADDR_W -: REG_ADDR_W];
  assign rs2    = ir_q[REG_ADDR_W-1:0];
  assign fire   = req_q & imem_ack;

  // Register read ports; the two top indices return their constants.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (rs1 == REG_ADDR_W'(i)) rs1_val = regs_q[i];
      if (rs2 == REG_ADDR_W'(i)) rs2_val = regs_q[i];
    end
    if (rs1 == REG_ADDR_W'(NUM_REGS-2)) rs1_val = DATA_REGFIXED_INIT_0;
    if (rs1 == REG_ADDR_W'(NUM_REGS-1)) rs1_val = DATA_REGFIXED_INIT_1;
    if (rs2 == REG_ADDR_W'(NUM_REGS-2)) rs2_val = DATA_REGFIXED_INIT_0;
    if (rs2 == REG_ADDR_W'(NUM_REGS-1)) rs2_val = DATA_REGFIXED_INIT_1;
  end

  uproc_alu #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS)
  ) u_alu (
    .op_i    (opcode),
    .a_i     (rs1_val),
    .b_i     (rs2_val),
    .result_o(alu_res),
    .flags_o (alu_flags)
  );

  // Next-state, datapath updates and the registered fetch request.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    flags_d     = flags_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    we          = 1'b0;
    wdata       = alu_res;
    case (state_q)
      ST_FETCH: begin
        if (fire) begin
          ir_d    = imem_rdata[INSTR_W-1 -: IR_W];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HALT)       state_d = ST_HALT;
        else if (is_two_word(opcode)) state_d = ST_FETCH_IMM;
        else                          state_d = ST_EXEC;
      end
      ST_FETCH_IMM: begin
        if (fire) begin
          imm_d   = imem_rdata[IMM_W-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PC_W'(1);
        if (updates_flags(opcode)) begin
          flags_d = alu_flags;
          we      = 1'b1;
        end
        case (opcode)
          OP_LDI: begin
            we    = 1'b1;
            wdata = imm_q[DATAWIDTH_BUS-1:0];
            pc_d  = pc_q + PC_W'(2);
          end
          OP_MOV: begin
            we    = 1'b1;
            wdata = rs1_val;
          end
          OP_BZ:  pc_d = flags_q[FLAG_Z] ? imm_q[PC_W-1:0] : pc_q + PC_W'(2);
          OP_JMP: pc_d = imm_q[PC_W-1:0];
          OP_OUT: begin
            out_data_d  = rs1_val;
            out_valid_d = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Request is registered so it is low during reset and rises one clock after release.
  assign req_d = (state_d == ST_FETCH) || (state_d == ST_FETCH_IMM);

  // Control and datapath state registers.
  always_ff @(posedge CLOCK_50 or negedge Reset_InLow) begin
    if (!Reset_InLow) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      imm_q       <= '0;
      flags_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      flags_q     <= flags_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      req_q       <= req_d;
    end
  end

  // Writable registers; a destination in the fixed range matches no entry and is dropped.
  always_ff @(posedge CLOCK_50 or negedge Reset_InLow) begin
    if (!Reset_InLow) begin
      for (int unsigned i = 0; i < NUM_WR; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (rd == REG_ADDR_W'(i)) regs_q[i] <= wdata;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = (state_q == ST_FETCH_IMM) ? pc_q + PC_W'(1) : pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign flags     = flags_q;
  assign pc_dbg    = pc_q;
  assign halted    = (state_q == ST_HALT);

endmodule
